// File: rtl/cluster_unpacker768.sv
// Cluster unpacker: rebuilds start, count and hit maps
// from a stream of (adr, cnt) cluster words per frame.
module cluster_unpacker768 #(
  parameter int MXPADS     = 768,
  parameter int MXCLUSTERS = 8
) (
  input  logic                  clock,
  input  logic                  global_reset,
  input  logic                  clust_valid,
  input  logic [10:0]           clust_adr,
  input  logic [2:0]            clust_cnt,
  input  logic                  clust_last,
  output logic [MXPADS-1:0]     vpfs_out,
  output logic [MXPADS*3-1:0]   cnts_out,
  output logic [MXPADS-1:0]     hits_out,
  output logic                  out_valid,
  output logic [3:0]            out_nclusters,
  output logic                  err_overflow,
  output logic                  err_adr,
  output logic                  err_dup
);

  logic                r_valid;
  logic                r_last;
  logic [10:0]         r_adr;
  logic [2:0]          r_cnt;
  logic                close_q;

  logic [MXPADS-1:0]   work_vpf;
  logic [MXPADS-1:0]   work_hits;
  logic [MXPADS*3-1:0] work_cnt;
  logic [3:0]          work_n;
  logic                work_ovf;
  logic                work_aerr;
  logic                work_dup;

  logic [MXPADS-1:0]   base_vpf;
  logic [MXPADS-1:0]   base_hits;
  logic [MXPADS*3-1:0] base_cnt;
  logic [3:0]          base_n;

  logic [MXPADS-1:0]   nxt_vpf;
  logic [MXPADS-1:0]   nxt_hits;
  logic [MXPADS*3-1:0] nxt_cnt;
  logic [3:0]          nxt_n;
  logic                nxt_ovf;
  logic                nxt_aerr;
  logic                nxt_dup;

  logic [7:0]          mask8;
  logic [MXPADS-1:0]   onehot;
  logic [MXPADS-1:0]   span;
  logic                adr_bad;
  logic                full;
  logic                acc;

  // Pad one-hot decode and hit span; bits past the last pad fall off
  always_comb begin
    mask8  = 8'hff >> (3'd7 - r_cnt);
    onehot = {{(MXPADS-1){1'b0}}, 1'b1} << r_adr;
    span   = {{(MXPADS-8){1'b0}}, mask8} << r_adr;
  end

  // Next working frame; a just-closed frame restarts from empty
  always_comb begin
    base_vpf  = close_q ? '0 : work_vpf;
    base_hits = close_q ? '0 : work_hits;
    base_cnt  = close_q ? '0 : work_cnt;
    base_n    = close_q ? '0 : work_n;
    nxt_vpf   = base_vpf;
    nxt_hits  = base_hits;
    nxt_cnt   = base_cnt;
    nxt_n     = base_n;
    nxt_ovf   = close_q ? 1'b0 : work_ovf;
    nxt_aerr  = close_q ? 1'b0 : work_aerr;
    nxt_dup   = close_q ? 1'b0 : work_dup;
    adr_bad   = r_adr >= 11'(MXPADS);
    full      = base_n == 4'(MXCLUSTERS);
    acc       = r_valid && !adr_bad && !full;
    if (r_valid && adr_bad) begin
      nxt_aerr = 1'b1;
    end else if (r_valid && full) begin
      nxt_ovf = 1'b1;
    end else if (acc) begin
      if ((base_vpf & onehot) != '0) nxt_dup = 1'b1;
      nxt_vpf  = base_vpf | onehot;
      nxt_hits = base_hits | span;
      nxt_n    = base_n + 4'd1;
      for (int i = 0; i < MXPADS; i++) begin
        if (onehot[i]) nxt_cnt[i*3 +: 3] = r_cnt;
      end
    end
  end

  // Input register, free running
  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_adr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_valid <= clust_valid;
      r_last  <= clust_last;
      r_adr   <= clust_adr;
      r_cnt   <= clust_cnt;
    end
  end

  // Working frame accumulation and close tracking
  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      work_vpf  <= '0;
      work_hits <= '0;
      work_cnt  <= '0;
      work_n    <= '0;
      work_ovf  <= 1'b0;
      work_aerr <= 1'b0;
      work_dup  <= 1'b0;
      close_q   <= 1'b0;
    end else begin
      work_vpf  <= nxt_vpf;
      work_hits <= nxt_hits;
      work_cnt  <= nxt_cnt;
      work_n    <= nxt_n;
      work_ovf  <= nxt_ovf;
      work_aerr <= nxt_aerr;
      work_dup  <= nxt_dup;
      close_q   <= r_last;
    end
  end

  // Publish the closed frame and pulse out_valid
  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      vpfs_out      <= '0;
      cnts_out      <= '0;
      hits_out      <= '0;
      out_nclusters <= '0;
      err_overflow  <= 1'b0;
      err_adr       <= 1'b0;
      err_dup       <= 1'b0;
      out_valid     <= 1'b0;
    end else begin
      out_valid <= close_q;
      if (close_q) begin
        vpfs_out      <= work_vpf;
        cnts_out      <= work_cnt;
        hits_out      <= work_hits;
        out_nclusters <= work_n;
        err_overflow  <= work_ovf;
        err_adr       <= work_aerr;
        err_dup       <= work_dup;
      end
    end
  end

endmodule

// File: tb/tb_cluster_unpacker768.sv
// Testbench for cluster_unpacker768: directed and random
// frames checked against a per-frame reference model.
module tb_cluster_unpacker768;

  localparam int NP = 768;
  localparam int NC = 8;

  logic            clock = 1'b0;
  logic            global_reset;
  logic            clust_valid;
  logic [10:0]     clust_adr;
  logic [2:0]      clust_cnt;
  logic            clust_last;
  logic [NP-1:0]   vpfs_out;
  logic [NP*3-1:0] cnts_out;
  logic [NP-1:0]   hits_out;
  logic            out_valid;
  logic [3:0]      out_nclusters;
  logic            err_overflow;
  logic            err_adr;
  logic            err_dup;

  cluster_unpacker768 dut (
    .clock(clock),
    .global_reset(global_reset),
    .clust_valid(clust_valid),
    .clust_adr(clust_adr),
    .clust_cnt(clust_cnt),
    .clust_last(clust_last),
    .vpfs_out(vpfs_out),
    .cnts_out(cnts_out),
    .hits_out(hits_out),
    .out_valid(out_valid),
    .out_nclusters(out_nclusters),
    .err_overflow(err_overflow),
    .err_adr(err_adr),
    .err_dup(err_dup)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit v;
    int adr;
    int cnt;
    bit last;
  } word_t;

  typedef struct {
    logic [NP-1:0]   vpf;
    logic [NP*3-1:0] cnts;
    logic [NP-1:0]   hits;
    int              n;
    bit              eo;
    bit              ea;
    bit              ed;
    int              cyc;
  } frm_t;

  int    ntests = 0;
  int    nfail  = 0;
  int    cyc    = 0;
  word_t pend[$];
  frm_t  expq[$];
  int    lastq[$];
  frm_t  snaps[$];
  frm_t  lastexp;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (out_valid) begin
      frm_t s;
      s.vpf  = vpfs_out;
      s.cnts = cnts_out;
      s.hits = hits_out;
      s.n    = int'(out_nclusters);
      s.eo   = err_overflow;
      s.ea   = err_adr;
      s.ed   = err_dup;
      s.cyc  = cyc;
      snaps.push_back(s);
    end
  end

  function automatic frm_t model(input word_t q[$]);
    frm_t e;
    e.vpf = '0; e.cnts = '0; e.hits = '0;
    e.n = 0; e.eo = 0; e.ea = 0; e.ed = 0; e.cyc = 0;
    foreach (q[k]) begin
      if (q[k].v) begin
        if (q[k].adr >= NP) e.ea = 1;
        else if (e.n == NC) e.eo = 1;
        else begin
          if (e.vpf[q[k].adr]) e.ed = 1;
          e.vpf[q[k].adr] = 1'b1;
          e.cnts[q[k].adr*3 +: 3] = 3'(q[k].cnt);
          for (int p = q[k].adr; p <= q[k].adr + q[k].cnt; p++)
            if (p < NP) e.hits[p] = 1'b1;
          e.n++;
        end
      end
    end
    return e;
  endfunction

  task automatic chk_s(input string tag, input int o, input int e);
    ntests++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic chk_v(input string tag, input logic [NP*3-1:0] o,
                       input logic [NP*3-1:0] e);
    int d;
    ntests++;
    assert (o === e) else begin
      nfail++;
      d = -1;
      for (int i = NP*3-1; i >= 0; i--) if (o[i] !== e[i]) d = i;
      $error("FAIL %s observed_ones=%0d expected_ones=%0d first_diff_bit=%0d",
             tag, $countones(o), $countones(e), d);
    end
  endtask

  task automatic send(input bit v, input int adr, input int cnt,
                      input bit last);
    word_t w;
    w.v = v; w.adr = adr; w.cnt = cnt; w.last = last;
    clust_valid = v;
    clust_adr   = 11'(adr);
    clust_cnt   = 3'(cnt);
    clust_last  = last;
    pend.push_back(w);
    if (last) begin
      expq.push_back(model(pend));
      lastq.push_back(cyc);
      pend.delete();
    end
    @(negedge clock);
  endtask

  task automatic idle();
    clust_valid = 0; clust_adr = '0; clust_cnt = '0; clust_last = 0;
    @(negedge clock);
  endtask

  task automatic collect(input string tag);
    frm_t e, s;
    int   lc, t;
    idle();
    while (expq.size() > 0) begin
      e  = expq.pop_front();
      lc = lastq.pop_front();
      t  = 0;
      while (snaps.size() == 0 && t < 10) begin
        @(negedge clock);
        t++;
      end
      if (snaps.size() == 0) begin
        chk_s({tag, "_timeout"}, 0, 1);
      end else begin
        s = snaps.pop_front();
        chk_s({tag, "_lat"}, s.cyc - lc, 3);
        chk_v({tag, "_vpf"}, {{(NP*2){1'b0}}, s.vpf}, {{(NP*2){1'b0}}, e.vpf});
        chk_v({tag, "_cnt"}, s.cnts, e.cnts);
        chk_v({tag, "_hit"}, {{(NP*2){1'b0}}, s.hits}, {{(NP*2){1'b0}}, e.hits});
        chk_s({tag, "_n"}, s.n, e.n);
        chk_s({tag, "_err"}, {s.eo, s.ea, s.ed}, {e.eo, e.ea, e.ed});
        lastexp = e;
      end
    end
    repeat (3) @(negedge clock);
    chk_s({tag, "_extra_pulse"}, snaps.size(), 0);
    snaps.delete();
    chk_v({tag, "_hold"}, {{(NP*2){1'b0}}, vpfs_out},
          {{(NP*2){1'b0}}, lastexp.vpf});
  endtask

  initial begin
    int nw;
    global_reset = 1;
    clust_valid = 0; clust_adr = '0; clust_cnt = '0; clust_last = 0;
    repeat (2) @(negedge clock);
    chk_s("rst_valid", int'(out_valid), 0);
    chk_s("rst_n", int'(out_nclusters), 0);
    chk_v("rst_vpf", {{(NP*2){1'b0}}, vpfs_out}, '0);
    chk_v("rst_cnt", cnts_out, '0);
    chk_s("rst_err", {err_overflow, err_adr, err_dup}, 0);
    global_reset = 0;
    @(negedge clock);

    send(1, 5, 2, 0);
    global_reset = 1;
    pend.delete();
    @(negedge clock);
    global_reset = 0;
    idle();
    send(1, 9, 0, 1);
    collect("rstmid");

    send(1, 0, 7, 0);
    send(1, 100, 3, 1);
    collect("two");
    chk_s("two_cnt0", int'(cnts_out[2:0]), 7);
    chk_s("two_cnt100", int'(cnts_out[302:300]), 3);

    send(1, 765, 7, 1);
    collect("edge");
    send(1, 768, 0, 1);
    collect("badadr");

    for (int i = 0; i < 9; i++) send(1, i*10, 0, i == 8);
    collect("ovf");

    send(1, 50, 1, 0);
    send(1, 50, 4, 1);
    collect("dup");

    send(0, 0, 0, 1);
    send(1, 3, 0, 1);
    collect("b2b");

    for (int f = 0; f < 40; f++) begin
      nw = $urandom_range(0, 11);
      for (int k = 0; k < nw; k++) begin
        if ($urandom_range(0, 7) == 0)
          send(1, $urandom_range(NP, 2047), $urandom_range(0, 7), 0);
        else if ($urandom_range(0, 3) == 0)
          send(1, $urandom_range(NP-10, NP-1), $urandom_range(0, 7), 0);
        else
          send($urandom_range(0, 5) != 0, $urandom_range(0, 63),
               $urandom_range(0, 7), 0);
      end
      send($urandom_range(0, 1), $urandom_range(0, NP-1),
           $urandom_range(0, 7), 1);
      if ($urandom_range(0, 2) == 0) send(1, $urandom_range(0, NP-1),
                                          $urandom_range(0, 7), 1);
      collect("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
